// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative divider: FSM state encodings and result defaults.
// Imported by div_iter and div_iter_step.
package div_iter_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Quotient reported for any divide by zero (all ones, as a full restoring pass yields).
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_iter_step.sv
// One combinational restoring-division step: shift {rem,quo} left, then subtract the
// divisor from the remainder when it fits and record a 1 in the quotient LSB.
module div_iter_step
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [2*WIDTH:0] pair_sh;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             fits;

  assign pair_sh = {rem_i, quo_i} << 1;
  assign rem_sh  = pair_sh[2*WIDTH:WIDTH];
  assign diff    = rem_sh - {1'b0, div_i};
  assign fits    = rem_sh >= {1'b0, div_i};

  assign rem_o = fits ? diff : rem_sh;
  assign quo_o = {pair_sh[WIDTH-1:1], fits};

endmodule

// File: rtl/div_iter.sv
// Iterative WIDTH-bit restoring divider (DIV/DIVU) feeding the HI/LO write muxes.
// Optional `DIV_EARLY_OUT_EN: skip iteration when divisor==0 or |dividend|<|divisor|.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             sa, sb, launch, div_zero;
  logic [WIDTH-1:0] abs_a, abs_b;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign sa       = is_signed & dividend[WIDTH-1];
  assign sb       = is_signed & divisor[WIDTH-1];
  // 0x80000000 negates to itself, which is its correct magnitude when read unsigned.
  assign abs_a    = sa ? -dividend : dividend;
  assign abs_b    = sb ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign launch   = start && (state_q != S_CALC);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    q_d       = q_q;
    r_d       = r_q;

    case (state_q)
      S_CALC: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          q_d     = neg_quo_q ? -step_quo : step_quo;
          r_d     = neg_rem_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d   = S_CALC;
      count_d   = '0;
      rem_d     = '0;
      quo_d     = abs_a;
      div_d     = abs_b;
      // A zero divisor must report an all-ones quotient regardless of operand signs.
      neg_quo_d = (sa ^ sb) & ~div_zero;
      neg_rem_d = sa;
`ifdef DIV_EARLY_OUT_EN
      if (div_zero || (abs_a < abs_b)) begin
        state_d = S_DONE;
        q_d     = div_zero ? DIV_ZERO_Q[WIDTH-1:0] : '0;
        r_d     = dividend;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all datapath registers are cleared on reset, so an aborted op leaves q/r at zero.
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge _d values together.
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      q_q       <= q_d;
      r_q       <= r_d;
    end
  end

  assign busy = (state_q == S_CALC);
  assign done = (state_q == S_DONE);
  assign q    = q_q;
  assign r    = r_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, multi-cycle corner sequences
// and random operations against an arithmetic reference model.
module tb_div_iter;
  import div_iter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;

  int total  = 0;
  int passed = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      passed++;
  endtask

  // Reference: MIPS truncating division from plain integer arithmetic.
  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eq, output logic [31:0] er);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      eq = DIV_ZERO_Q;
      er = a;
    end else if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      qq = sa / sb;
      rr = sa % sb;
      eq = qq[31:0];
      er = rr[31:0];
    end else begin
      eq = a / b;
      er = a % b;
    end
  endtask

  function automatic int exp_latency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = sgn ? longint'(signed'(a)) : longint'(a);
    mb = sgn ? longint'(signed'(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
    if (mb == 0 || ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Caller sits at a negedge; the start edge is the next posedge.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
  endtask

  // Counts cycles after the start edge until done is seen (bounded).
  task automatic wait_done(output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_and_check(input string name, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    int lat, busy_n, el;
    ref_div(sgn, a, b, eq, er);
    el = exp_latency(sgn, a, b);
    @(negedge clk);
    launch(sgn, a, b);
    wait_done(lat, busy_n);
    check({name, " q"}, q, eq);
    check({name, " r"}, r, er);
    check({name, " latency"}, lat, el);
    check({name, " busy cycles"}, busy_n, el - 1);
  endtask

  initial begin
    vec_t vecs[$];
    int   lat, busy_n, done_n;
    logic [31:0] ra, rb, eq, er;
    logic rs;

    vecs.push_back('{"divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2});
    vecs.push_back('{"div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF});
    vecs.push_back('{"div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1});
    vecs.push_back('{"div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0});
    vecs.push_back('{"divu_ovf_ops", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000});
    vecs.push_back('{"divu_by0",     1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234});
    vecs.push_back('{"div_by0",      1'b1, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234});
    vecs.push_back('{"div_neg_by0",  1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB});
    vecs.push_back('{"div_m8_m3",    1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE});
    vecs.push_back('{"divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0});
    vecs.push_back('{"divu_0_5",     1'b0, 32'd0,          32'd5,          32'd0,          32'd0});
    vecs.push_back('{"divu_small",   1'b0, 32'd3,          32'd10,         32'd0,          32'd3});

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset q", q, 0);
    check("reset r", r, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(lat, busy_n);
      check({vecs[i].name, " q"}, q, vecs[i].exp_q);
      check({vecs[i].name, " r"}, r, vecs[i].exp_r);
      check({vecs[i].name, " latency"}, lat, exp_latency(vecs[i].sgn, vecs[i].a, vecs[i].b));
      check({vecs[i].name, " busy cycles"}, busy_n,
            exp_latency(vecs[i].sgn, vecs[i].a, vecs[i].b) - 1);
      @(negedge clk);
      check({vecs[i].name, " done single pulse"}, done, 0);
    end

    // start during CALC is dropped; the first op's result stands.
    @(negedge clk);
    launch(1'b0, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat < 10) begin @(negedge clk); lat++; end
    launch(1'b0, 32'd50, 32'd3);
    @(negedge clk);
    start = 1'b0;
    lat++;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    check("ignored start latency", lat, 33);
    check("ignored start q", q, 32'd14);
    check("ignored start r", r, 32'd2);
    done_n = 0;
    repeat (40) begin @(negedge clk); if (done || busy) done_n++; end
    check("ignored start not queued", done_n, 0);

    // Back-to-back: start in the DONE cycle launches op 2.
    @(negedge clk);
    launch(1'b0, 32'd1000, 32'd3);
    wait_done(lat, busy_n);
    check("b2b op1 done", done, 1);
    check("b2b op1 q", q, 32'd333);
    check("b2b op1 r", r, 32'd1);
    launch(1'b1, 32'hFFFF_FF00, 32'd16);
    wait_done(lat, busy_n);
    check("b2b op2 latency", lat, 33);
    check("b2b op2 q", q, 32'hFFFF_FFF0);
    check("b2b op2 r", r, 32'd0);

    // Reset pulsed at cycle 12 of an op aborts it with cleared outputs.
    run_and_check("pre_reset", 1'b0, 32'd100, 32'd7);
    @(negedge clk);
    launch(1'b0, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", busy, 0);
    check("abort q", q, 0);
    check("abort r", r, 0);
    done_n = 0;
    repeat (40) begin if (done) done_n++; @(negedge clk); end
    check("abort no done", done_n, 0);

    // Random operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom();
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2, 3: rb = $urandom_range(1, 15);
        4:       rb = 32'hFFFF_FFFF;
        5:       rb = $urandom_range(1, 65535);
        default: rb = $urandom();
      endcase
      ref_div(rs, ra, rb, eq, er);
      @(negedge clk);
      launch(rs, ra, rb);
      wait_done(lat, busy_n);
      check("rand q", q, eq);
      check("rand r", r, er);
      check("rand latency", lat, exp_latency(rs, ra, rb));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
